// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, funct codes, ALU control codes,
// ALU-op selectors and the multicycle controller state encoding.
package mips_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field values for R-type instructions
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU-op selector from the main controller to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Multicycle controller states (encoding is visible on the debug port)
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11,
    ST_BNEEX   = 4'd12
  } state_e;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle. The master side is the controller: it
// reads instruction fields and status, and drives enables and selects.
interface mips_mc_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 pcen;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regwrite;
  logic                 alusrca;
  logic                 iord;
  logic                 memtoreg;
  logic                 regdst;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 illegal;
  logic                 mem_err;
  logic [3:0]           state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
    output alusrcb, pcsrc, alucontrol, illegal, mem_err, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
    input  alusrcb, pcsrc, alucontrol, illegal, mem_err, state
  );
endinterface

// File: rtl/mips_aludec.sv
// Combinational ALU decoder shared by the multicycle and single-cycle cores.
// aluop selects add, sub, or decode from funct; funct_bad_o flags an
// unsupported funct only when funct decoding is requested.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_bad_o
);

  // Map aluop/funct to the ALU operation code
  always_comb begin
    alucontrol_o = ALU_ADD;
    funct_bad_o  = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alucontrol_o = ALU_ADD;
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: begin
            alucontrol_o = ALU_ADD;
            funct_bad_o  = 1'b1;
          end
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller with memory-wait timeout.
// Optional feature: define MIPS_MC_BNE_EN to decode bne (op 000101) into
// BNEEX; otherwise bne is reported as an illegal opcode.
// Enables are combinational from state and inputs and are forced low
// asynchronously while reset is high.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_MAX  = 15
) (
  input  logic clk,
  input  logic reset,
  mips_mc_controller_if.master bus
);

  localparam logic [3:0] S_FETCH   = ST_FETCH;
  localparam logic [3:0] S_DECODE  = ST_DECODE;
  localparam logic [3:0] S_MEMADR  = ST_MEMADR;
  localparam logic [3:0] S_MEMRD   = ST_MEMRD;
  localparam logic [3:0] S_MEMWB   = ST_MEMWB;
  localparam logic [3:0] S_MEMWR   = ST_MEMWR;
  localparam logic [3:0] S_RTYPEEX = ST_RTYPEEX;
  localparam logic [3:0] S_RTYPEWB = ST_RTYPEWB;
  localparam logic [3:0] S_BEQEX   = ST_BEQEX;
  localparam logic [3:0] S_ADDIEX  = ST_ADDIEX;
  localparam logic [3:0] S_ADDIWB  = ST_ADDIWB;
  localparam logic [3:0] S_JEX     = ST_JEX;
  localparam logic [3:0] S_BNEEX   = ST_BNEEX;

  // Wait counter holds the number of stalled cycles already spent in the
  // current memory state; timeout fires in the WAIT_MAX-th stalled cycle.
  localparam int          CNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int unsigned WAIT_LAST = (WAIT_MAX == 0) ? 0 : WAIT_MAX - 1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic       pcen_s, memwrite_s, irwrite_s, regwrite_s;
  logic       alusrca_s, iord_s, memtoreg_s, regdst_s;
  logic [1:0] alusrcb_s, pcsrc_s, aluop_s;
  logic       illegal_s, mem_err_s, mem_wait_s, timeout_s;
  logic [2:0] alu3_s;
  logic       funct_bad_s;

  mips_aludec u_aludec (
    .aluop_i      (aluop_s),
    .funct_i      (bus.funct),
    .alucontrol_o (alu3_s),
    .funct_bad_o  (funct_bad_s)
  );

  assign timeout_s = (WAIT_MAX != 0) && (wait_q == CNT_W'(WAIT_LAST));

  // Next-state, wait counter and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    wait_d     = {CNT_W{1'b0}};
    pcen_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    aluop_s    = ALUOP_ADD;
    illegal_s  = 1'b0;
    mem_err_s  = 1'b0;
    mem_wait_s = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb_s = 2'b01;
        if (bus.mem_ready) begin
          irwrite_s = 1'b1;
          pcen_s    = 1'b1;
          state_d   = S_DECODE;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        if (bus.op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord_s = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else begin
          mem_wait_s = 1'b1;
        end
      end
      S_RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
        if (funct_bad_s) begin
          illegal_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_RTYPEWB;
        end
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        pcen_s    = bus.zero;
        state_d   = S_FETCH;
      end
`ifdef MIPS_MC_BNE_EN
      S_BNEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        pcen_s    = ~bus.zero;
        state_d   = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc_s = 2'b10;
        pcen_s  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A stall that hits the limit abandons the access; mem_ready in the
    // same cycle means mem_wait_s is low, so completion wins.
    if (mem_wait_s && timeout_s) begin
      mem_err_s = 1'b1;
      state_d   = S_FETCH;
    end else if (mem_wait_s) begin
      if (wait_q != {CNT_W{1'b1}}) begin
        wait_d = wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_d = wait_q;
      end
    end else begin
      wait_d = {CNT_W{1'b0}};
    end
  end

  // State and wait counter registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.pcen       = pcen_s     & ~reset;
  assign bus.memwrite   = memwrite_s & ~reset;
  assign bus.irwrite    = irwrite_s  & ~reset;
  assign bus.regwrite   = regwrite_s & ~reset;
  assign bus.illegal    = illegal_s  & ~reset;
  assign bus.mem_err    = mem_err_s  & ~reset;
  assign bus.alusrca    = alusrca_s;
  assign bus.iord       = iord_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.regdst     = regdst_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = ALUCTRL_W'(alu3_s);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: each driven cycle pushes the
// expected control word (value + care mask) and a negedge monitor pops and
// compares it against the DUT outputs.
module tb_mips_mc_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                         S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7, S_BEQEX = 4'd8,
                         S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX = 4'd11,
                         S_BNEEX = 4'd12;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b110, A_SLT = 3'b111;
  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                         O_BNE = 6'b000101, O_ADDI = 6'b001000,
                         O_LW = 6'b100011, O_SW = 6'b101011, O_BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [21:0] v;
    logic [21:0] m;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb_q[$];
  logic [21:0] obs_s;

  mips_mc_controller_if #(.ALUCTRL_W(3)) bus ();

  mips_mc_controller #(.ALUCTRL_W(3), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Observed control word: state, enables, selects, alucontrol, pulses
  assign obs_s = {bus.state, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                  bus.iord, bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb,
                  bus.pcsrc, bus.alucontrol, bus.illegal, bus.mem_err, 1'b0};

  initial clk = 1'b0;
  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected control word for one cycle, from the per-state output table
  function automatic void build_exp(input logic [3:0] st, input logic rdy, input logic zr,
                                    input logic [2:0] alu_e, input logic ill, input logic merr,
                                    output logic [21:0] v, output logic [21:0] m);
    v = '0;
    m = '0;
    v[21:18] = st;  m[21:18] = 4'hF;
    m[17:14] = 4'hF;
    m[2:1]   = 2'b11;
    v[2] = ill;
    v[1] = merr;
    case (st)
      S_FETCH:  begin v[17] = rdy; v[15] = rdy; m[13] = 1'b1; m[10:3] = 8'hFF;
                      v[9:8] = 2'b01; v[5:3] = A_ADD; end
      S_DECODE: begin m[10:8] = 3'b111; m[5:3] = 3'b111; v[9:8] = 2'b11; v[5:3] = A_ADD; end
      S_MEMADR, S_ADDIEX: begin m[10:8] = 3'b111; m[5:3] = 3'b111;
                      v[10] = 1'b1; v[9:8] = 2'b10; v[5:3] = A_ADD; end
      S_MEMRD:  begin m[13] = 1'b1; v[13] = 1'b1; end
      S_MEMWR:  begin m[13] = 1'b1; v[13] = 1'b1; v[16] = 1'b1; end
      S_MEMWB:  begin v[14] = 1'b1; m[12:11] = 2'b11; v[12] = 1'b1; end
      S_ADDIWB: begin v[14] = 1'b1; m[12:11] = 2'b11; end
      S_RTYPEWB: begin v[14] = 1'b1; m[12:11] = 2'b11; v[11] = 1'b1; end
      S_RTYPEEX: begin m[10:8] = 3'b111; v[10] = 1'b1;
                       if (!ill) begin m[5:3] = 3'b111; v[5:3] = alu_e; end end
      S_BEQEX:  begin m[10:3] = 8'hFF; v[10] = 1'b1; v[7:6] = 2'b01; v[5:3] = A_SUB; v[17] = zr; end
      S_BNEEX:  begin m[10:3] = 8'hFF; v[10] = 1'b1; v[7:6] = 2'b01; v[5:3] = A_SUB; v[17] = ~zr; end
      S_JEX:    begin m[7:6] = 2'b11; v[7:6] = 2'b10; v[17] = 1'b1; end
      default:  begin m = m; end
    endcase
  endfunction

  // Drive one cycle of inputs, push its expectation, advance past the edge
  task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic rdy, input logic zr, input logic [3:0] st,
                     input logic [2:0] alu_e, input logic ill, input logic merr);
    exp_t e;
    bus.op = o;
    bus.funct = f;
    bus.mem_ready = rdy;
    bus.zero = zr;
    e.tag = tag;
    build_exp(st, rdy, zr, alu_e, ill, merr, e.v, e.m);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each pending expectation mid-cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs_s & e.m, e.v);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] al_tab [5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state: FETCH, no pulses, enables gated even with mem_ready high
    check_eq("rst_state", {18'd0, bus.state}, {18'd0, S_FETCH});
    check_eq("rst_en", {18'd0, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite}, 22'd0);
    check_eq("rst_pulse", {20'd0, bus.illegal, bus.mem_err}, 22'd0);
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    // lw with mem_ready always high
    cyc("lw_f",  O_LW, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("lw_d",  O_LW, 6'd0, 1'b1, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("lw_a",  O_LW, 6'd0, 1'b1, 1'b0, S_MEMADR, A_ADD, 1'b0, 1'b0);
    cyc("lw_r",  O_LW, 6'd0, 1'b1, 1'b0, S_MEMRD,  A_ADD, 1'b0, 1'b0);
    cyc("lw_wb", O_LW, 6'd0, 1'b1, 1'b0, S_MEMWB,  A_ADD, 1'b0, 1'b0);

    // sw with three stalled cycles in MEMWR
    cyc("sw_f", O_SW, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("sw_d", O_SW, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("sw_a", O_SW, 6'd0, 1'b0, 1'b0, S_MEMADR, A_ADD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("sw_wait", O_SW, 6'd0, 1'b0, 1'b0, S_MEMWR, A_ADD, 1'b0, 1'b0);
    cyc("sw_done", O_SW, 6'd0, 1'b1, 1'b0, S_MEMWR, A_ADD, 1'b0, 1'b0);

    // R-type for every supported funct
    for (int i = 0; i < 5; i++) begin
      cyc("r_f",  O_R, fn_tab[i], 1'b1, 1'b0, S_FETCH,   A_ADD,     1'b0, 1'b0);
      cyc("r_d",  O_R, fn_tab[i], 1'b0, 1'b0, S_DECODE,  A_ADD,     1'b0, 1'b0);
      cyc("r_ex", O_R, fn_tab[i], 1'b0, 1'b0, S_RTYPEEX, al_tab[i], 1'b0, 1'b0);
      cyc("r_wb", O_R, fn_tab[i], 1'b0, 1'b0, S_RTYPEWB, A_ADD,     1'b0, 1'b0);
    end

    // Unknown funct: illegal pulse, back to FETCH, no write
    cyc("rbad_f",  O_R, 6'b111111, 1'b1, 1'b0, S_FETCH,   A_ADD, 1'b0, 1'b0);
    cyc("rbad_d",  O_R, 6'b111111, 1'b0, 1'b0, S_DECODE,  A_ADD, 1'b0, 1'b0);
    cyc("rbad_ex", O_R, 6'b111111, 1'b0, 1'b0, S_RTYPEEX, A_ADD, 1'b1, 1'b0);

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      cyc("beq_f",  O_BEQ, 6'd0, 1'b1, 1'(z), S_FETCH,  A_ADD, 1'b0, 1'b0);
      cyc("beq_d",  O_BEQ, 6'd0, 1'b0, 1'(z), S_DECODE, A_ADD, 1'b0, 1'b0);
      cyc("beq_ex", O_BEQ, 6'd0, 1'b0, 1'(z), S_BEQEX,  A_ADD, 1'b0, 1'b0);
    end

    // addi and j
    cyc("addi_f",  O_ADDI, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("addi_d",  O_ADDI, 6'd0, 1'b1, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("addi_ex", O_ADDI, 6'd0, 1'b1, 1'b0, S_ADDIEX, A_ADD, 1'b0, 1'b0);
    cyc("addi_wb", O_ADDI, 6'd0, 1'b1, 1'b0, S_ADDIWB, A_ADD, 1'b0, 1'b0);
    cyc("j_f",  O_J, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("j_d",  O_J, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("j_ex", O_J, 6'd0, 1'b0, 1'b0, S_JEX,    A_ADD, 1'b0, 1'b0);

    // Unknown opcode
    cyc("opbad_f", O_BAD, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("opbad_d", O_BAD, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b1, 1'b0);

    // bne: optional branch or illegal opcode
`ifdef MIPS_MC_BNE_EN
    for (int z = 0; z < 2; z++) begin
      cyc("bne_f",  O_BNE, 6'd0, 1'b1, 1'(z), S_FETCH,  A_ADD, 1'b0, 1'b0);
      cyc("bne_d",  O_BNE, 6'd0, 1'b0, 1'(z), S_DECODE, A_ADD, 1'b0, 1'b0);
      cyc("bne_ex", O_BNE, 6'd0, 1'b0, 1'(z), S_BNEEX,  A_ADD, 1'b0, 1'b0);
    end
`else
    cyc("bne_f", O_BNE, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("bne_d", O_BNE, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b1, 1'b0);
`endif

    // FETCH timeout on the 15th stalled cycle, then counter restarts
    for (int i = 1; i <= 15; i++)
      cyc("to_fetch", O_J, 6'd0, 1'b0, 1'b0, S_FETCH, A_ADD, 1'b0, 1'(i == 15));
    // mem_ready in the 15th cycle completes normally
    for (int i = 1; i <= 14; i++)
      cyc("nto_wait", O_J, 6'd0, 1'b0, 1'b0, S_FETCH, A_ADD, 1'b0, 1'b0);
    cyc("nto_done", O_J, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("nto_d",    O_J, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("nto_ex",   O_J, 6'd0, 1'b0, 1'b0, S_JEX,    A_ADD, 1'b0, 1'b0);

    // MEMRD timeout: abort to FETCH with no register write
    cyc("tr_f", O_LW, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("tr_d", O_LW, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("tr_a", O_LW, 6'd0, 1'b0, 1'b0, S_MEMADR, A_ADD, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++)
      cyc("to_memrd", O_LW, 6'd0, 1'b0, 1'b0, S_MEMRD, A_ADD, 1'b0, 1'(i == 15));
    cyc("tr_back", O_LW, 6'd0, 1'b0, 1'b0, S_FETCH, A_ADD, 1'b0, 1'b0);

    // Reset in the middle of MEMWR drops memwrite without a clock edge
    cyc("mr_f", O_SW, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("mr_d", O_SW, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("mr_a", O_SW, 6'd0, 1'b0, 1'b0, S_MEMADR, A_ADD, 1'b0, 1'b0);
    cyc("mr_w", O_SW, 6'd0, 1'b0, 1'b0, S_MEMWR,  A_ADD, 1'b0, 1'b0);
    #1;
    check_eq("mr_pre_mw", {21'd0, bus.memwrite}, 22'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mr_mw", {21'd0, bus.memwrite}, 22'd0);
    check_eq("mr_state", {18'd0, bus.state}, {18'd0, S_FETCH});
    @(posedge clk); #1;
    reset = 1'b0;

    // Normal operation resumes from FETCH
    cyc("post_f",  O_ADDI, 6'd0, 1'b1, 1'b0, S_FETCH,  A_ADD, 1'b0, 1'b0);
    cyc("post_d",  O_ADDI, 6'd0, 1'b0, 1'b0, S_DECODE, A_ADD, 1'b0, 1'b0);
    cyc("post_ex", O_ADDI, 6'd0, 1'b0, 1'b0, S_ADDIEX, A_ADD, 1'b0, 1'b0);
    cyc("post_wb", O_ADDI, 6'd0, 1'b0, 1'b0, S_ADDIWB, A_ADD, 1'b0, 1'b0);

    check_eq("sb_empty", 22'(sb_q.size()), 22'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3: alucontrol width; bits above [2:0] are driven 0.
REQ-002 SHALL have parameter WAIT_MAX, default 15: memory-wait cycles before abort.
REQ-003 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have ports op and funct, input, 6 each: instruction opcode and function fields.
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1: memory access completes this cycle.
REQ-008 SHALL have ports pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg and regdst, output, 1 each: datapath enables and selects.
REQ-009 SHALL have ports alusrcb and pcsrc, output, 2 each: ALU B-operand and next-PC selects.
REQ-010 SHALL have port alucontrol, output, ALUCTRL_W: ALU operation.
REQ-011 SHALL have ports illegal and mem_err, output, 1 each: one-cycle error pulses.
REQ-012 SHALL have port state, output, 4: current FSM state encoding, for debug.

Function
REQ-013 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB and JEX.
REQ-014 SHALL take transitions as follows:
- FETCH to DECODE on mem_ready.
- DECODE by op: lw/sw (100011/101011) to MEMADR; 000000 to RTYPEEX; beq 000100 to BEQEX; addi 001000 to ADDIEX; j 000010 to JEX.
- MEMADR to MEMRD for lw, to MEMWR for sw.
- MEMRD to MEMWB on mem_ready.
- MEMWR to FETCH on mem_ready.
- RTYPEEX to RTYPEWB; ADDIEX to ADDIWB.
- MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX to FETCH.
REQ-015 SHALL drive these outputs in FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00; irwrite and pcen=1 only in the cycle mem_ready=1.
REQ-016 SHALL drive alusrca=0, alusrcb=11 and alucontrol=add in DECODE, to compute the branch target.
REQ-017 SHALL drive alusrca=1, alusrcb=10 and alucontrol=add in MEMADR and ADDIEX.
REQ-018 SHALL drive iord=1 in MEMRD and MEMWR, and memwrite=1 for every cycle spent in MEMWR.
REQ-019 SHALL drive regwrite=1, regdst=0 and memtoreg=1 in MEMWB.
REQ-020 SHALL drive regwrite=1 in ADDIWB, with regdst=0 and memtoreg=0.
REQ-021 SHALL drive regwrite=1 in RTYPEWB, with regdst=1 and memtoreg=0.
REQ-022 SHALL drive alusrca=1, alusrcb=00 and the funct-decoded alucontrol in RTYPEEX, using:
- 100000 add = 010;
- 100010 sub = 110;
- 100100 and = 000;
- 100101 or = 001;
- 101010 slt = 111.
REQ-023 SHALL drive alusrca=1, alusrcb=00, alucontrol=sub and pcsrc=01 in BEQEX, with pcen = zero.
REQ-024 SHALL drive pcsrc=10 and pcen=1 in JEX.
REQ-025 SHALL hold all enables (pcen, memwrite, irwrite, regwrite) at 0 in states where they are not listed above.
REQ-026 SHALL handle an unknown op in DECODE, or an unknown funct in RTYPEEX, by pulsing illegal for one cycle, going to FETCH, and writing nothing.
REQ-027 SHALL count consecutive cycles without mem_ready in FETCH, MEMRD and MEMWR, and clear the counter on entering any state.
REQ-028 SHALL pulse mem_err for one cycle and go to FETCH, with no register or IR write, when the counter reaches WAIT_MAX; WAIT_MAX=0 disables the timeout.
REQ-029 SHALL treat mem_ready arriving in the same cycle as the timeout as completion, with no mem_err.
REQ-030 SHALL ignore mem_ready in all non-memory states.

Reset
REQ-031 SHALL force state=FETCH, clear the wait counter, and drive illegal=0 and mem_err=0 immediately on reset assertion, independent of clk.
REQ-032 SHALL force all enables to 0 while reset=1, including mid-MEMWR, where memwrite SHALL drop asynchronously.
REQ-033 SHALL have FETCH as the first state evaluated on the first rising clk edge after reset deasserts.

Configuration
REQ-034 SHALL, with MIPS_MC_BNE_EN defined, decode op 000101 (bne) to state BNEEX, which behaves as BEQEX but with pcen = ~zero.
REQ-035 SHALL, without MIPS_MC_BNE_EN, treat op 000101 as illegal per REQ-026.

Structure
REQ-036 SHALL place in the shared package mips_pkg: the opcode and funct constants, the ALU control codes, and the state enumeration typedef.
REQ-037 SHALL implement funct and aluop decoding as sub-module mips_aludec, combinational and reusable by the single-cycle core.

Verification
REQ-038 SHALL cover: lw (op=100011) with mem_ready=1 every cycle -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-039 SHALL cover: sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for exactly 4 cycles, then FETCH.
REQ-040 SHALL cover: R-type funct=101010 -> alucontrol=111 in RTYPEEX, regdst=1 in RTYPEWB; funct=111111 -> illegal pulse, no regwrite.
REQ-041 SHALL cover: beq with zero=1 and then zero=0 -> pcen=1 and then pcen=0 in BEQEX, pcsrc=01 both times.
REQ-042 SHALL cover: WAIT_MAX=15 with mem_ready stuck 0 in FETCH -> mem_err pulse on the 15th wait cycle, state stays FETCH, irwrite never 1.
REQ-043 SHALL cover: reset asserted mid-MEMWR -> memwrite=0 and state=FETCH before the next clk edge; op=000101 -> BNEEX or illegal per the macro.
